// File: rtl/float_to_fixed_pkg.sv
// Packed-float format constants shared by float_to_fixed and the float arithmetic units.
// Layout is {sign, exponent, mantissa}, with the mantissa in the least significant bits.
package float_to_fixed_pkg;

    localparam int DEF_MANTISSA_SIZE   = 23;
    localparam int DEF_EXPONENT_SIZE   = 8;
    localparam int DEF_FIXED_SIZE      = 32;
    localparam int DEF_FRACTIONAL_BITS = 16;

    localparam int MANTISSA_POS = 0;
    localparam int EXPONENT_POS = MANTISSA_POS + DEF_MANTISSA_SIZE;
    localparam int SIGN_POS     = EXPONENT_POS + DEF_EXPONENT_SIZE;

    localparam int BIAS = 2 ** (DEF_EXPONENT_SIZE - 1) - 1;
    localparam logic [DEF_EXPONENT_SIZE-1:0] EXPONENT_INVALID_VALUE = '1;

    // Left shift that moves the integer mantissa onto the fixed-point grid (negative = right shift).
    function automatic int calc_shift(input int eff_exp, input int bias,
                                      input int mantissa_size, input int fractional_bits);
        return eff_exp - bias - mantissa_size + fractional_bits;
    endfunction

endpackage

// File: rtl/fixed_saturate.sv
// Applies the sign to an unsigned magnitude and clamps it into a signed FIXED_SIZE result.
// The magnitude carries one extra bit so that -2**(FIXED_SIZE-1) stays exactly representable.
module fixed_saturate #(
    parameter int FIXED_SIZE = 32
) (
    input  logic                  sign_in,
    input  logic [FIXED_SIZE:0]   magnitude_in,
    input  logic                  force_overflow_in,
    input  logic                  invalid_in,
    output logic [FIXED_SIZE-1:0] fixed_out,
    output logic                  overflow_out,
    output logic                  invalid_out
);

    localparam logic [FIXED_SIZE:0]   POS_LIMIT = {2'b00, {(FIXED_SIZE - 1){1'b1}}};
    localparam logic [FIXED_SIZE:0]   NEG_LIMIT = {2'b01, {(FIXED_SIZE - 1){1'b0}}};
    localparam logic [FIXED_SIZE-1:0] MAX_POS   = {1'b0, {(FIXED_SIZE - 1){1'b1}}};
    localparam logic [FIXED_SIZE-1:0] MIN_NEG   = {1'b1, {(FIXED_SIZE - 1){1'b0}}};

    always_comb begin
        fixed_out    = '0;
        overflow_out = 1'b0;
        invalid_out  = 1'b0;
        if (invalid_in) begin
            invalid_out = 1'b1;
        end else if (force_overflow_in || (magnitude_in > (sign_in ? NEG_LIMIT : POS_LIMIT))) begin
            overflow_out = 1'b1;
            fixed_out    = sign_in ? MIN_NEG : MAX_POS;
        end else begin
            fixed_out = sign_in ? -magnitude_in[FIXED_SIZE-1:0] : magnitude_in[FIXED_SIZE-1:0];
        end
    end

endmodule

// File: rtl/float_to_fixed.sv
// Three-stage packed-float to signed fixed-point converter: unpack, align, sign/saturate.
// Rounds toward zero and accepts one conversion per clock with no backpressure.
module float_to_fixed
    import float_to_fixed_pkg::*;
#(
    parameter int MANTISSA_SIZE   = DEF_MANTISSA_SIZE,
    parameter int EXPONENT_SIZE   = DEF_EXPONENT_SIZE,
    parameter int FIXED_SIZE      = DEF_FIXED_SIZE,
    parameter int FRACTIONAL_BITS = DEF_FRACTIONAL_BITS
) (
    input  logic                                 clk,
    input  logic                                 resetn,
    input  logic                                 valid_in,
    input  logic [EXPONENT_SIZE+MANTISSA_SIZE:0] float_in,
    output logic                                 valid_out,
    output logic [FIXED_SIZE-1:0]                fixed_out,
    output logic                                 overflow_out,
    output logic                                 invalid_out
);

    localparam int EXP_BIAS = 2 ** (EXPONENT_SIZE - 1) - 1;
    localparam int EXP_POS  = MANTISSA_POS + MANTISSA_SIZE;
    localparam int SGN_POS  = EXP_POS + EXPONENT_SIZE;
    localparam int SHIFT_W  = EXPONENT_SIZE + 2;
    localparam int M_W      = MANTISSA_SIZE + 1;
    localparam int MAG_W    = FIXED_SIZE + 1;

    logic [EXPONENT_SIZE-1:0] exponent;
    logic [MANTISSA_SIZE-1:0] mantissa;
    logic [EXPONENT_SIZE-1:0] eff_exp;

    logic                      s1_valid_d, s1_valid_q;
    logic                      s1_sign_d, s1_sign_q;
    logic [M_W-1:0]            s1_mant_d, s1_mant_q;
    logic signed [SHIFT_W-1:0] s1_shift_d, s1_shift_q;
    logic                      s1_special_d, s1_special_q;
    logic                      s1_nan_d, s1_nan_q;

    logic             s2_valid_d, s2_valid_q;
    logic             s2_sign_d, s2_sign_q;
    logic [MAG_W-1:0] s2_mag_d, s2_mag_q;
    logic             s2_ovf_d, s2_ovf_q;
    logic             s2_nan_d, s2_nan_q;

    int               shift_amt;
    logic [MAG_W-1:0] mant_ext;

    logic [FIXED_SIZE-1:0] sat_fixed;
    logic                  sat_ovf;
    logic                  sat_inv;

    logic                  out_valid_d, out_valid_q;
    logic [FIXED_SIZE-1:0] out_fixed_d, out_fixed_q;
    logic                  out_ovf_d, out_ovf_q;
    logic                  out_inv_d, out_inv_q;

    // Denormals share exponent 1 with the smallest normal, just without the hidden bit.
    always_comb begin
        exponent     = float_in[EXP_POS +: EXPONENT_SIZE];
        mantissa     = float_in[MANTISSA_POS +: MANTISSA_SIZE];
        eff_exp      = (exponent == '0) ? EXPONENT_SIZE'(1) : exponent;
        s1_valid_d   = valid_in;
        s1_sign_d    = float_in[SGN_POS];
        s1_mant_d    = {exponent != '0, mantissa};
        s1_shift_d   = SHIFT_W'(calc_shift(int'(eff_exp), EXP_BIAS, MANTISSA_SIZE, FRACTIONAL_BITS));
        s1_special_d = &exponent;
        s1_nan_d     = (&exponent) && (mantissa != '0);
    end

    // Any set mantissa bit pushed past the extended magnitude width means the value cannot fit.
    always_comb begin
        shift_amt  = int'(s1_shift_q);
        mant_ext   = MAG_W'(s1_mant_q);
        s2_valid_d = s1_valid_q;
        s2_sign_d  = s1_sign_q;
        s2_nan_d   = s1_nan_q;
        s2_ovf_d   = s1_special_q && !s1_nan_q;
        s2_mag_d   = '0;
        if (shift_amt >= 0) begin
            s2_mag_d = mant_ext << shift_amt;
            for (int i = 0; i < M_W; i++) begin
                if (s1_mant_q[i] && ((i + shift_amt) >= MAG_W)) begin
                    s2_ovf_d = 1'b1;
                end
            end
        end else if (-shift_amt <= MANTISSA_SIZE) begin
            s2_mag_d = mant_ext >> (-shift_amt);
        end
    end

    fixed_saturate #(
        .FIXED_SIZE(FIXED_SIZE)
    ) u_saturate (
        .sign_in          (s2_sign_q),
        .magnitude_in     (s2_mag_q),
        .force_overflow_in(s2_ovf_q),
        .invalid_in       (s2_nan_q),
        .fixed_out        (sat_fixed),
        .overflow_out     (sat_ovf),
        .invalid_out      (sat_inv)
    );

    always_comb begin
        out_valid_d = s2_valid_q;
        out_fixed_d = sat_fixed;
        out_ovf_d   = sat_ovf;
        out_inv_d   = sat_inv;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_mant_q    <= '0;
            s1_shift_q   <= '0;
            s1_special_q <= 1'b0;
            s1_nan_q     <= 1'b0;
            s2_valid_q   <= 1'b0;
            s2_sign_q    <= 1'b0;
            s2_mag_q     <= '0;
            s2_ovf_q     <= 1'b0;
            s2_nan_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_fixed_q  <= '0;
            out_ovf_q    <= 1'b0;
            out_inv_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_mant_q    <= s1_mant_d;
            s1_shift_q   <= s1_shift_d;
            s1_special_q <= s1_special_d;
            s1_nan_q     <= s1_nan_d;
            s2_valid_q   <= s2_valid_d;
            s2_sign_q    <= s2_sign_d;
            s2_mag_q     <= s2_mag_d;
            s2_ovf_q     <= s2_ovf_d;
            s2_nan_q     <= s2_nan_d;
            out_valid_q  <= out_valid_d;
            out_fixed_q  <= out_fixed_d;
            out_ovf_q    <= out_ovf_d;
            out_inv_q    <= out_inv_d;
        end
    end

    assign valid_out    = out_valid_q;
    assign fixed_out    = out_fixed_q;
    assign overflow_out = out_ovf_q;
    assign invalid_out  = out_inv_q;

endmodule

// File: tb/tb_float_to_fixed.sv
// Bench for float_to_fixed: hand-computed directed vectors plus a real-arithmetic reference
// model checked against the outputs on every cycle, including across an in-flight reset.
module tb_float_to_fixed;
    import float_to_fixed_pkg::*;

    logic        clk = 1'b0;
    logic        resetn;
    logic        valid_in;
    logic [31:0] float_in;
    logic        valid_out;
    logic [31:0] fixed_out;
    logic        overflow_out;
    logic        invalid_out;

    int vectors     = 0;
    int miscompares = 0;

    // {valid_in, float_in} as sampled on the last three rising edges, oldest first.
    logic [32:0] hist[$];

    float_to_fixed dut (
        .clk         (clk),
        .resetn      (resetn),
        .valid_in    (valid_in),
        .float_in    (float_in),
        .valid_out   (valid_out),
        .fixed_out   (fixed_out),
        .overflow_out(overflow_out),
        .invalid_out (invalid_out)
    );

    always #5 clk = ~clk;

    // Reference: value of the float as a real number, scaled by 2^16 and truncated toward zero.
    function automatic void refConvert(input logic [31:0] f, output logic [31:0] fx,
                                       output logic ovf, output logic inv);
        logic       s;
        logic [7:0] e;
        logic [22:0] m;
        int         eff;
        real        v;
        real        lim;
        longint     mag;
        s   = f[SIGN_POS];
        e   = f[EXPONENT_POS +: 8];
        m   = f[22:0];
        fx  = '0;
        ovf = 1'b0;
        inv = 1'b0;
        if (e == EXPONENT_INVALID_VALUE) begin
            if (m != 0) begin
                inv = 1'b1;
            end else begin
                ovf = 1'b1;
                fx  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end
        end else begin
            eff = (e == 0) ? 1 : int'(e);
            v   = ((e == 0) ? 0.0 : 1.0) + real'(m) / 8388608.0;
            v   = v * (2.0 ** (eff - BIAS)) * 65536.0;
            lim = s ? 2147483648.0 : 2147483647.0;
            if (v > lim) begin
                ovf = 1'b1;
                fx  = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
            end else begin
                mag = longint'($floor(v));
                fx  = s ? 32'(-mag) : 32'(mag);
            end
        end
    endfunction

    task automatic compareValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] f, input logic v);
        @(negedge clk);
        valid_in = v;
        float_in = f;
    endtask

    // Waits a bounded number of cycles for the result and checks latency and value.
    task automatic checkOutput(input string name, input logic [31:0] exp_fx,
                               input logic exp_ovf, input logic exp_inv);
        int lat;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 1) valid_in = 1'b0;
            if (valid_out === 1'b1) begin
                lat = c;
                break;
            end
        end
        compareValue({name, "_latency"}, 32'(lat), 32'd3);
        compareValue({name, "_fixed"}, fixed_out, exp_fx);
        compareValue({name, "_overflow"}, 32'(overflow_out), 32'(exp_ovf));
        compareValue({name, "_invalid"}, 32'(invalid_out), 32'(exp_inv));
    endtask

    task automatic runLiteral(input string name, input logic [31:0] f, input logic [31:0] exp_fx,
                              input logic exp_ovf, input logic exp_inv);
        applyStimulus(f, 1'b1);
        checkOutput(name, exp_fx, exp_ovf, exp_inv);
    endtask

    always @(posedge clk) begin
        if (!resetn) begin
            hist.delete();
        end else begin
            hist.push_back({valid_in, float_in});
            if (hist.size() > 3) void'(hist.pop_front());
        end
    end

    always @(negedge clk) begin : compare_proc
        logic [31:0] efx;
        logic        eovf;
        logic        einv;
        logic        ev;
        if (!resetn) begin
            compareValue("reset_valid", 32'(valid_out), 32'd0);
            compareValue("reset_fixed", fixed_out, 32'd0);
            compareValue("reset_overflow", 32'(overflow_out), 32'd0);
            compareValue("reset_invalid", 32'(invalid_out), 32'd0);
        end else begin
            ev = (hist.size() == 3) ? hist[0][32] : 1'b0;
            compareValue("stream_valid", 32'(valid_out), 32'(ev));
            if (ev) begin
                refConvert(hist[0][31:0], efx, eovf, einv);
                compareValue("stream_fixed", fixed_out, efx);
                compareValue("stream_overflow", 32'(overflow_out), 32'(eovf));
                compareValue("stream_invalid", 32'(invalid_out), 32'(einv));
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pat[8] = '{1, 1, 0, 1, 0, 0, 1, 1};
        resetn   = 1'b1;
        valid_in = 1'b0;
        float_in = '0;
        #1 resetn = 1'b0;
        repeat (3) @(negedge clk);
        #2 resetn = 1'b1;

        runLiteral("one",       32'h3F80_0000, 32'h0001_0000, 1'b0, 1'b0);
        runLiteral("neg2p5",    32'hC020_0000, 32'hFFFD_8000, 1'b0, 1'b0);
        runLiteral("neg32768",  32'hC700_0000, 32'h8000_0000, 1'b0, 1'b0);
        runLiteral("pos32768",  32'h4700_0000, 32'h7FFF_FFFF, 1'b1, 1'b0);
        runLiteral("neg_inf",   32'hFF80_0000, 32'h8000_0000, 1'b1, 1'b0);
        runLiteral("nan",       32'h7FC0_0000, 32'h0000_0000, 1'b0, 1'b1);
        runLiteral("tiny",      32'h3380_0000, 32'h0000_0000, 1'b0, 1'b0);
        runLiteral("neg_zero",  32'h8000_0000, 32'h0000_0000, 1'b0, 1'b0);
        runLiteral("frac_trunc", 32'hBF80_0001, 32'hFFFF_0000, 1'b0, 1'b0);
        runLiteral("denormal",  32'h0040_0000, 32'h0000_0000, 1'b0, 1'b0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus({1'($urandom), 8'($urandom_range(150, 100)), 23'($urandom)}, pat[i] != 0);
        end
        applyStimulus(32'h0, 1'b0);
        repeat (5) @(negedge clk);

        applyStimulus(32'h3F80_0000, 1'b1);
        applyStimulus(32'hC020_0000, 1'b1);
        applyStimulus(32'h0, 1'b0);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        compareValue("async_reset_valid", 32'(valid_out), 32'd0);
        compareValue("async_reset_fixed", fixed_out, 32'd0);
        compareValue("async_reset_overflow", 32'(overflow_out), 32'd0);
        compareValue("async_reset_invalid", 32'(invalid_out), 32'd0);
        repeat (2) @(negedge clk);
        #2 resetn = 1'b1;
        repeat (4) @(negedge clk);
        runLiteral("after_reset", 32'h3F80_0000, 32'h0001_0000, 1'b0, 1'b0);
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/float_to_fixed.md
Name: float_to_fixed

Overview:
- Pipelined converter from the team's packed float format to signed two's-complement fixed point.
- It performs the inverse of the packing stage used by the float arithmetic units: unpack, de-normalize by exponent, then apply sign.
- It sits at the boundary between the float datapath and the fixed-point consumers: DAC/pixel/coordinate logic.
- Throughput is one conversion per clock.

Parameters:
- MANTISSA_SIZE, 23, stored mantissa bits, hidden bit not included.
- EXPONENT_SIZE, 8, exponent bits; BIAS = 2**(EXPONENT_SIZE-1)-1.
- FIXED_SIZE, 32, total output width, signed.
- FRACTIONAL_BITS, 16, fractional bits of the output (Q format FIXED_SIZE-FRACTIONAL_BITS . FRACTIONAL_BITS).

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous, active-low reset
- valid_in  in  1  float_in qualifier
- float_in  in  1+EXPONENT_SIZE+MANTISSA_SIZE  packed {sign, exponent, mantissa}
- valid_out  out  1  fixed_out/flags qualifier
- fixed_out  out  FIXED_SIZE  signed result
- overflow_out  out  1  result saturated (magnitude too large, or Inf)
- invalid_out  out  1  input was NaN

Behaviour:
- Reset (async assert, sync release): valid_out=0, fixed_out=0, overflow_out=0, invalid_out=0. All stage valid bits clear. In-flight data is discarded.
- Latency is exactly 3 cycles from valid_in sampled high to valid_out high. No stall or backpressure; the pipeline advances every clock.
- Data registers may load regardless of valid. Outputs are meaningful only when valid_out=1.
- Stage 1 (unpack):
  - Hidden bit = (exponent != 0).
  - Effective exponent = max(exponent, 1), so denormals use exponent 1.
  - M = {hidden, mantissa}.
  - shift = eff_exp - BIAS - MANTISSA_SIZE + FRACTIONAL_BITS, signed, width EXPONENT_SIZE+2.
  - Flag isSpecial = (exponent == all ones); isNaN = isSpecial && mantissa != 0.
- Stage 2 (align):
  - shift >= 0: magnitude = M << shift, computed in FIXED_SIZE+1 bits. Precompute overflow if any bit of M would leave FIXED_SIZE+1 bits.
  - shift < 0: magnitude = M >> -shift, truncating toward zero. If -shift > MANTISSA_SIZE, magnitude = 0.
  - Zero input (exp=0, mantissa=0) yields magnitude 0 for either sign; -0 maps to 0.
- Stage 3 (sign/saturate/register):
  - Positive limit 2**(FIXED_SIZE-1)-1; negative limit magnitude 2**(FIXED_SIZE-1), which is representable exactly.
  - Magnitude above the limit for its sign, or Inf: fixed_out = 0x7FF..F (positive) or 0x800..0 (negative), overflow_out=1.
  - NaN: fixed_out=0, invalid_out=1, overflow_out=0.
  - Otherwise fixed_out = sign ? -magnitude : magnitude, with both flags 0.
- Rounding is always toward zero. No rounding-mode input.
- Back-to-back valid_in with bubbles: valid_out reproduces the exact valid pattern delayed by 3 cycles.

Decomposition:
- Shared float package holds:
  - field position constants (MANTISSA_POS, EXPONENT_POS, SIGN_POS);
  - BIAS and EXPONENT_INVALID_VALUE;
  - a helper function computing the signed shift amount.
- The same constants are reused by the arithmetic units.
- One sub-module is natural: fixed_saturate (stage-3 negate + clamp, parameterised by FIXED_SIZE). It is reusable by a later fixed-point accumulator.

Test Plan (default parameters):
- 0x3F800000 (1.0) -> fixed_out=0x00010000, flags 0, valid_out exactly 3 cycles after valid_in.
- 0xC0200000 (-2.5) -> 0xFFFD8000; 0xC7000000 (-32768.0) -> 0x80000000 with overflow_out=0.
- 0x47000000 (32768.0) -> 0x7FFFFFFF, overflow_out=1; 0xFF800000 (-Inf) -> 0x80000000, overflow_out=1.
- 0x7FC00000 (NaN) -> 0x00000000, invalid_out=1; 0x33800000 (2^-24) and 0x80000000 (-0) -> 0x00000000, flags 0.
- Stream 8 random finite values back-to-back with valid_in pattern 1,1,0,1,0,0,1,1 -> valid_out follows the same pattern 3 cycles later; each result matches the reference model truncated toward zero.
- Assert resetn low while 2 conversions are in flight -> valid_out and all outputs immediately 0. No stale valid_out after release; the next input converts correctly.
